// File: rtl/lift_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : lift_pkg
// Desc   : Shared car-controller state encoding and floor-width constants.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package lift_pkg;

  localparam int FLOOR_W    = 4;
  localparam int MAX_FLOORS = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/lift_req_scan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : lift_req_scan
// Desc   : Flags pending requests above, below and at the current floor.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module lift_req_scan
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = 11
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic                  above,
  output logic                  below,
  output logic                  here
);

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    here  = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i]) begin
        if (i > int'(cur_floor))  above = 1'b1;
        if (i < int'(cur_floor))  below = 1'b1;
        if (i == int'(cur_floor)) here  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lift_car_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : lift_car_controller
// Desc   : Collective-scheduling car controller; LIFT_OVERLOAD_EN adds an
//          overload input that holds the door open.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module lift_car_controller
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS  = 11,
  parameter int FLOOR_TICKS = 8,
  parameter int DOOR_TICKS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef LIFT_OVERLOAD_EN
  input  logic                  overload,
`endif
  input  logic                  assign_valid,
  input  logic [FLOOR_W-1:0]    assign_floor,
  output logic                  assign_err,
  output logic [FLOOR_W-1:0]    liftstate,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  served_valid,
  output logic [FLOOR_W-1:0]    served_floor,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open
);

  localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TMR_W     = $clog2(MAX_TICKS);
  localparam logic [TMR_W-1:0]   FLOOR_LOAD  = TMR_W'(FLOOR_TICKS - 1);
  localparam logic [TMR_W-1:0]   DOOR_LOAD   = TMR_W'(DOOR_TICKS - 1);
  localparam logic [FLOOR_W:0]   FLOOR_LIMIT = NUM_FLOORS[FLOOR_W:0];

  if (NUM_FLOORS < 1 || NUM_FLOORS > MAX_FLOORS || FLOOR_TICKS < 2 || DOOR_TICKS < 1)
  begin : g_param_check
    $error("lift_car_controller: parameter out of range");
  end

  state_t                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic                    dir_up_q, dir_up_d;
  logic                    served_valid_q, served_valid_d;
  logic [FLOOR_W-1:0]      served_floor_q, served_floor_d;
  logic                    assign_err_q, assign_err_d;

  logic                    above, below, here;
  logic                    assign_in_range, reassign_here, assign_set;
  logic [FLOOR_W-1:0]      next_floor, door_floor;
  logic                    hit_next, door_enter, door_hold;

`ifdef LIFT_OVERLOAD_EN
  assign door_hold = overload;
`else
  assign door_hold = 1'b0;
`endif

  lift_req_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan (
    .pending   (pending_q),
    .cur_floor (floor_q),
    .above     (above),
    .below     (below),
    .here      (here)
  );

  assign assign_in_range = {1'b0, assign_floor} < FLOOR_LIMIT;
  // A request for the floor whose door is already open is served in place.
  assign reassign_here   = assign_valid && (state_q == DOOR_OPEN) && (assign_floor == floor_q);
  assign assign_set      = assign_valid && assign_in_range && !reassign_here;
  assign assign_err_d    = assign_valid && !assign_in_range;
  assign next_floor      = (state_q == MOVE_DOWN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);

  always_comb begin
    hit_next = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && (int'(next_floor) == i)) hit_next = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    floor_d        = floor_q;
    timer_d        = timer_q;
    dir_up_d       = dir_up_q;
    served_valid_d = 1'b0;
    served_floor_d = served_floor_q;
    door_enter     = 1'b0;
    door_floor     = floor_q;
    case (state_q)
      IDLE: begin
        if (here) begin
          state_d    = DOOR_OPEN;
          door_enter = 1'b1;
        end else if (above && (dir_up_q || !below)) begin
          state_d  = MOVE_UP;
          dir_up_d = 1'b1;
          timer_d  = FLOOR_LOAD;
        end else if (below) begin
          state_d  = MOVE_DOWN;
          dir_up_d = 1'b0;
          timer_d  = FLOOR_LOAD;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (timer_q == '0) begin
          floor_d = next_floor;
          // Ahead-of-new-floor equals ahead-of-old-floor once the new floor itself is not pending.
          if (hit_next) begin
            state_d    = DOOR_OPEN;
            door_enter = 1'b1;
            door_floor = next_floor;
          end else if ((state_q == MOVE_UP) ? above : below) begin
            timer_d = FLOOR_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      DOOR_OPEN: begin
        if (reassign_here) begin
          timer_d        = DOOR_LOAD;
          served_valid_d = 1'b1;
          served_floor_d = floor_q;
        end else if (door_hold) begin
          timer_d = DOOR_LOAD;
        end else if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (door_enter) begin
      timer_d        = DOOR_LOAD;
      served_valid_d = 1'b1;
      served_floor_d = door_floor;
    end
  end

  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (assign_set && (int'(assign_floor) == i)) pending_d[i] = 1'b1;
      if (door_enter && (int'(door_floor) == i))   pending_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      floor_q        <= '0;
      pending_q      <= '0;
      timer_q        <= '0;
      dir_up_q       <= 1'b1;
      served_valid_q <= 1'b0;
      served_floor_q <= '0;
      assign_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      floor_q        <= floor_d;
      pending_q      <= pending_d;
      timer_q        <= timer_d;
      dir_up_q       <= dir_up_d;
      served_valid_q <= served_valid_d;
      served_floor_q <= served_floor_d;
      assign_err_q   <= assign_err_d;
    end
  end

  assign assign_err   = assign_err_q;
  assign liftstate    = floor_q;
  assign pending      = pending_q;
  assign served_valid = served_valid_q;
  assign served_floor = served_floor_q;
  assign moving_up    = (state_q == MOVE_UP);
  assign moving_down  = (state_q == MOVE_DOWN);
  assign door_open    = (state_q == DOOR_OPEN);

endmodule
`default_nettype wire

// File: tb/tb_lift_car_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_lift_car_controller
// Desc   : Directed self-checking bench for lift_car_controller (defaults).
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_lift_car_controller;

  localparam int NF = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          overload;
  logic          assign_valid;
  logic [3:0]    assign_floor;
  logic          assign_err;
  logic [3:0]    liftstate;
  logic [NF-1:0] pending;
  logic          served_valid;
  logic [3:0]    served_floor;
  logic          moving_up;
  logic          moving_down;
  logic          door_open;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lift_car_controller #(
    .NUM_FLOORS  (NF),
    .FLOOR_TICKS (8),
    .DOOR_TICKS  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef LIFT_OVERLOAD_EN
    .overload     (overload),
`endif
    .assign_valid (assign_valid),
    .assign_floor (assign_floor),
    .assign_err   (assign_err),
    .liftstate    (liftstate),
    .pending      (pending),
    .served_valid (served_valid),
    .served_floor (served_floor),
    .moving_up    (moving_up),
    .moving_down  (moving_down),
    .door_open    (door_open)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle assignment strobe; returns on the negedge after the accepting edge.
  task automatic do_assign(input logic [3:0] f);
    assign_valid = 1'b1;
    assign_floor = f;
    @(negedge clk);
    assign_valid = 1'b0;
    assign_floor = 4'd0;
  endtask

  task automatic wait_served(input int budget, output logic [3:0] fl, output int cyc,
                             output bit found, output bit saw_down);
    found    = 1'b0;
    saw_down = 1'b0;
    cyc      = 0;
    fl       = 4'd0;
    while (!found && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (moving_down) saw_down = 1'b1;
      if (served_valid) begin
        found = 1'b1;
        fl    = served_floor;
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] fl;
    int         cyc;
    bit         found;
    bit         saw_down;
    int         pulses;

    rst          = 1'b1;
    overload     = 1'b0;
    assign_valid = 1'b0;
    assign_floor = 4'd0;
    step(2);
    check("rst_liftstate", liftstate, 0);
    check("rst_pending", pending, 0);
    check("rst_moving_up", moving_up, 0);
    check("rst_moving_down", moving_down, 0);
    check("rst_door", door_open, 0);
    check("rst_served", served_valid, 0);
    check("rst_err", assign_err, 0);
    check("rst_served_floor", served_floor, 0);
    rst = 1'b0;
    step(1);

    // Floor 0 -> 3, one floor per 8 cycles, then a 4-cycle door.
    do_assign(4'd3);
    check("t1_pending", pending, 32'h008);
    check("t1_still_idle", moving_up, 0);
    step(1);
    check("t1_move_up", moving_up, 1);
    check("t1_floor0", liftstate, 0);
    step(7);
    check("t1_floor0_late", liftstate, 0);
    step(1);
    check("t1_floor1", liftstate, 1);
    step(8);
    check("t1_floor2", liftstate, 2);
    step(8);
    check("t1_floor3", liftstate, 3);
    check("t1_door", door_open, 1);
    check("t1_served", served_valid, 1);
    check("t1_served_floor", served_floor, 3);
    check("t1_pending_clr", pending, 0);
    check("t1_up_off", moving_up, 0);
    step(1);
    check("t1_served_once", served_valid, 0);
    step(2);
    check("t1_door_last", door_open, 1);
    step(1);
    check("t1_door_closed", door_open, 0);
    check("t1_idle_up", moving_up, 0);
    check("t1_idle_down", moving_down, 0);

    // Get to floor 4, then re-request floor 4 from IDLE.
    do_assign(4'd4);
    wait_served(20, fl, cyc, found, saw_down);
    check("t3_reach_found", found, 1);
    check("t3_reach_floor", fl, 4);
    check("t3_reach_cycles", cyc, 9);
    step(4);
    check("t3_idle", door_open, 0);
    do_assign(4'd4);
    check("t3_pending", pending, 32'h010);
    check("t3_door_not_yet", door_open, 0);
    step(1);
    check("t3_door", door_open, 1);
    check("t3_floor", liftstate, 4);
    check("t3_served", served_valid, 1);
    check("t3_served_floor", served_floor, 4);
    check("t3_pending_clr", pending, 0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (served_valid) pulses++;
    end
    check("t3_extra_pulses", pulses, 0);
    check("t3_door_last", door_open, 1);
    step(1);
    check("t3_door_closed", door_open, 0);
    check("t3_no_move", moving_up | moving_down, 0);

    // Out-of-range request.
    do_assign(4'd11);
    check("t4_err", assign_err, 1);
    check("t4_pending", pending, 0);
    step(1);
    check("t4_err_once", assign_err, 0);
    check("t4_idle", {moving_up, moving_down, door_open}, 0);
    check("t4_floor", liftstate, 4);

    // Floor 4 -> 6, re-request 6 after two door cycles.
    do_assign(4'd6);
    step(17);
    check("t5_floor", liftstate, 6);
    check("t5_door", door_open, 1);
    check("t5_served", served_valid, 1);
    step(1);
    check("t5_served_gap", served_valid, 0);
    do_assign(4'd6);
    check("t5_reserved", served_valid, 1);
    check("t5_reserved_floor", served_floor, 6);
    check("t5_pending", pending, 0);
    check("t5_door_a", door_open, 1);
    step(3);
    check("t5_door_b", door_open, 1);
    check("t5_pending_b", pending, 0);
    step(1);
    check("t5_door_closed", door_open, 0);

    // Synchronous-edge reset from floor 6.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("r2_floor", liftstate, 0);

    // Collective: heading up to 7, a request for 2 arrives at floor 5.
    do_assign(4'd7);
    step(41);
    check("t2_floor5", liftstate, 5);
    check("t2_moving_up", moving_up, 1);
    do_assign(4'd2);
    check("t2_pending", pending, 32'h084);
    wait_served(40, fl, cyc, found, saw_down);
    check("t2_first_found", found, 1);
    check("t2_first_floor", fl, 7);
    check("t2_no_down_before", saw_down, 0);
    check("t2_first_cycles", cyc, 15);
    wait_served(80, fl, cyc, found, saw_down);
    check("t2_second_found", found, 1);
    check("t2_second_floor", fl, 2);
    check("t2_went_down", saw_down, 1);
    check("t2_second_cycles", cyc, 45);
    check("t2_liftstate", liftstate, 2);
    check("t2_pending_clr", pending, 0);
    step(4);
    check("t2_idle", door_open, 0);

    // Asynchronous reset between floors 2 and 3.
    do_assign(4'd3);
    step(5);
    check("t6_pre_floor", liftstate, 2);
    check("t6_pre_up", moving_up, 1);
    check("t6_pre_pending", pending, 32'h008);
    rst = 1'b1;
    #1;
    check("t6_async_floor", liftstate, 0);
    check("t6_async_pending", pending, 0);
    check("t6_async_up", moving_up, 0);
    step(1);
    rst = 1'b0;
    step(2);
    check("t6_after_idle", {moving_up, moving_down, door_open}, 0);
    check("t6_after_floor", liftstate, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
